// File: rtl/branch_predict_table_pkg.sv
// Shared encodings for the branch predictor: 2-bit direction counter states
// and the saturation limit of the statistics counters.
package branch_predict_table_pkg;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/branch_predict_table_sat_counter2.sv
// Combinational next state of a 2-bit saturating direction counter,
// moving toward taken or not-taken and clamping at the strong states.
module sat_counter2
  import branch_predict_table_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_table.sv
// Direct-mapped branch target buffer with 2-bit direction counters, decode-stage
// update and mispredict flush. Define BPT_GSHARE_EN to hash the index with global history.
module branch_predict_table
  import branch_predict_table_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int ENTRIES = 16,
  parameter int GHR_W   = 4,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_pc_plus_two,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
`ifdef BPT_GSHARE_EN
  input  logic [GHR_W-1:0] upd_ghr,
`endif
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     branch_cnt,
  output logic [15:0]     mispred_cnt
);

  localparam int TAG_W = PC_W - 1 - IDX_W;

  logic [ENTRIES-1:0] ent_valid;
  logic [TAG_W-1:0]   ent_tag [ENTRIES];
  logic [PC_W-1:0]    ent_tgt [ENTRIES];
  logic [1:0]         ent_ctr [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [1:0]       ctr_nxt;

  function automatic logic [15:0] stat_sat_inc(input logic [15:0] c);
    return (c == STAT_MAX) ? c : c + 16'd1;
  endfunction

  // Bit 0 of the PCs is always zero for halfword-aligned instructions.
  logic unused_pc_lsb;
  assign unused_pc_lsb = lookup_pc[0] ^ upd_pc[0];

  assign lk_tag = lookup_pc[PC_W-1:IDX_W+1];
  assign up_tag = upd_pc[PC_W-1:IDX_W+1];

`ifdef BPT_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  function automatic logic [IDX_W-1:0] hist_pad(input logic [GHR_W-1:0] h);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < IDX_W && i < GHR_W; i++) r[i] = h[i];
    return r;
  endfunction

  // Update must hash with the history the lookup saw, carried down the pipe.
  assign lk_idx = lookup_pc[IDX_W:1] ^ hist_pad(ghr);
  assign up_idx = upd_pc[IDX_W:1] ^ hist_pad(upd_ghr);

  always_ff @(posedge clk) begin
    if (!rst)           ghr <= '0;
    else if (upd_valid) ghr <= {ghr[GHR_W-2:0], upd_taken};
  end
`else
  logic [GHR_W-1:0] unused_ghr_w;
  assign unused_ghr_w = '0;
  assign lk_idx = lookup_pc[IDX_W:1];
  assign up_idx = upd_pc[IDX_W:1];
`endif

  // Lookup: tag compare is gated by valid so stale storage never drives pred_*.
  assign lk_hit      = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && ent_ctr[lk_idx][1];
  assign pred_target = pred_taken ? ent_tgt[lk_idx] : lookup_pc + PC_W'(2);

  assign up_hit = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);

  sat_counter2 u_sat_counter2 (
    .ctr      (ent_ctr[up_idx]),
    .taken    (upd_taken),
    .ctr_next (ctr_nxt)
  );

  assign flush = upd_valid &&
                 ((upd_taken != upd_pred_taken) ||
                  (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = (flush && upd_taken) ? upd_target : upd_pc_plus_two;

  // Control state: valid bits, counters and statistics; reset wins over update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_valid   <= '0;
      for (int i = 0; i < ENTRIES; i++) ent_ctr[i] <= CTR_RESET;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd_valid) begin
      branch_cnt <= stat_sat_inc(branch_cnt);
      if (flush) mispred_cnt <= stat_sat_inc(mispred_cnt);
      if (up_hit) begin
        ent_ctr[up_idx] <= ctr_nxt;
      end else if (upd_taken) begin
        ent_valid[up_idx] <= 1'b1;
        ent_ctr[up_idx]   <= CTR_ALLOC;
      end
    end
  end

  // Tag/target storage needs no reset; only taken updates write it.
  always_ff @(posedge clk) begin
    if (rst && upd_valid && upd_taken) begin
      ent_tag[up_idx] <= up_tag;
      ent_tgt[up_idx] <= upd_target;
    end
  end

endmodule
